// File: rtl/recover_pkg.sv
// recover_pkg: shared types and helpers for the recover_accum block.
//   state_e   : accumulator FSM states (S_IDLE, S_ACCUM)
//   mode_e    : reduction operation selector
//   log2_pow2 : log2 of a power-of-two elaboration parameter
package recover_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_MEAN_TRUNC = 2'd0,
    MODE_MEAN_ROUND = 2'd1,
    MODE_MAX        = 2'd2,
    MODE_MIN        = 2'd3
  } mode_e;

  // Exact for powers of two; only used on elaboration-time constants.
  function automatic int unsigned log2_pow2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/recover_reduce_step.sv
// recover_reduce_step: one combinational reduction step of recover_accum.
//   mode_i  : operation (sum for both means, running max or running min)
//   acc_i   : accumulator value before this element
//   elem_i  : pixel being consumed
//   first_i : element 0 seeds the accumulator instead of combining with it
//   acc_o   : accumulator value after this element
module recover_reduce_step
  import recover_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ACC_WIDTH   = 10
) (
  input  mode_e                  mode_i,
  input  logic [ACC_WIDTH-1:0]   acc_i,
  input  logic [PIXEL_WIDTH-1:0] elem_i,
  input  logic                   first_i,
  output logic [ACC_WIDTH-1:0]   acc_o
);

  logic [ACC_WIDTH-1:0] elem_ext;

  assign elem_ext = ACC_WIDTH'(elem_i);

  // Seed on the first element, otherwise fold the element into the accumulator.
  always_comb begin
    acc_o = elem_ext;
    if (!first_i) begin
      case (mode_i)
        MODE_MEAN_TRUNC,
        MODE_MEAN_ROUND: acc_o = acc_i + elem_ext;
        MODE_MAX:        acc_o = (elem_ext > acc_i) ? elem_ext : acc_i;
        MODE_MIN:        acc_o = (elem_ext < acc_i) ? elem_ext : acc_i;
        default:         acc_o = elem_ext;
      endcase
    end
  end

endmodule

// File: rtl/recover_accum.sv
// recover_accum: reduces IMAGE_NUMBER pixels (one per cycle) to a mean
// (truncated or rounded), maximum or minimum.
//   clk, rst_n       : clock, synchronous active-low reset
//   calculate_start  : operation request, accepted when idle or on the finishing edge
//   mode             : 0 mean trunc, 1 mean round, 2 max, 3 min
//   images           : one pixel per image, snapshotted at start
//   calculate_busy   : high while accumulating
//   calculate_finish : one-cycle pulse alongside a new result
//   calculate_result : registered result, held until the next finish
module recover_accum
  import recover_pkg::*;
#(
  parameter int unsigned IMAGE_NUMBER = 4,
  parameter int unsigned PIXEL_WIDTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     calculate_start,
  input  logic [1:0]                               mode,
  input  logic [IMAGE_NUMBER-1:0][PIXEL_WIDTH-1:0] images,
  output logic                                     calculate_busy,
  output logic                                     calculate_finish,
  output logic [PIXEL_WIDTH-1:0]                   calculate_result
);

  localparam int unsigned LOG2_N   = log2_pow2(IMAGE_NUMBER);
  localparam int unsigned ACC_W    = PIXEL_WIDTH + LOG2_N;
  localparam int unsigned IDX_W    = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int unsigned HALF_N   = IMAGE_NUMBER / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGE_NUMBER - 1);

  // Parameter legality
  if ((IMAGE_NUMBER < 2) || (IMAGE_NUMBER > 64) ||
      ((IMAGE_NUMBER & (IMAGE_NUMBER - 1)) != 0)) begin : g_bad_image_number
    $error("recover_accum: IMAGE_NUMBER must be a power of two in 2..64");
  end
  if ((PIXEL_WIDTH < 1) || (PIXEL_WIDTH > 16)) begin : g_bad_pixel_width
    $error("recover_accum: PIXEL_WIDTH must be in 1..16");
  end

  state_e                                   state_q;
  logic [IDX_W-1:0]                         cnt_q;
  logic [ACC_W-1:0]                         acc_q;
  logic [IMAGE_NUMBER-1:0][PIXEL_WIDTH-1:0] snap_q;
  mode_e                                    mode_q;
  logic                                     finish_q;
  logic [PIXEL_WIDTH-1:0]                   result_q;

  logic [ACC_W-1:0]       acc_d;
  logic [ACC_W-1:0]       round_d;
  logic [PIXEL_WIDTH-1:0] result_d;

  // Single shared reduction step, fed from the snapshot in ascending order
  recover_reduce_step #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .ACC_WIDTH   (ACC_W)
  ) u_step (
    .mode_i  (mode_q),
    .acc_i   (acc_q),
    .elem_i  (snap_q[cnt_q]),
    .first_i (cnt_q == '0),
    .acc_o   (acc_d)
  );

  // Final value includes the element consumed this cycle. The rounding add
  // cannot overflow ACC_W: N*(2^P-1) + N/2 < N*2^P.
  always_comb begin
    round_d  = acc_d + ACC_W'(HALF_N);
    result_d = PIXEL_WIDTH'(acc_d);
    case (mode_q)
      MODE_MEAN_TRUNC: result_d = PIXEL_WIDTH'(acc_d >> LOG2_N);
      MODE_MEAN_ROUND: result_d = PIXEL_WIDTH'(round_d >> LOG2_N);
      default:         result_d = PIXEL_WIDTH'(acc_d);
    endcase
  end

  // Control FSM. A start seen on the finishing edge reloads the snapshot and
  // stays in S_ACCUM, so a held start yields one result every IMAGE_NUMBER cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      snap_q   <= '0;
      mode_q   <= MODE_MEAN_TRUNC;
      finish_q <= 1'b0;
      result_q <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (calculate_start) begin
            snap_q  <= images;
            mode_q  <= mode_e'(mode);
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            result_q <= result_d;
            finish_q <= 1'b1;
            if (calculate_start) begin
              snap_q <= images;
              mode_q <= mode_e'(mode);
              cnt_q  <= '0;
              acc_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign calculate_busy   = (state_q == S_ACCUM);
  assign calculate_finish = finish_q;
  assign calculate_result = result_q;

endmodule
